// File: rtl/median_pkg.sv
// ============================================================================
// Module      : median_pkg
// Description : Shared state encoding and default widths for the median
//               filter, its feeder and their benches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package median_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int DATA_SAYISI_DEF = 25;

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  typedef enum logic [1:0] {
    S_FILL = FILL,
    S_SEND = SEND,
    S_WAIT = WAIT,
    S_OUT  = OUT
  } state_t;

  // Address counters need at least one bit even for a single-byte frame.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/feeder_frame_buf.sv
// ============================================================================
// Module      : feeder_frame_buf
// Description : DEPTH x DATA_W simple dual-port frame RAM, one write port and
//               one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module feeder_frame_buf #(
  parameter int DEPTH  = 25,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read register holds its value when idle so the last sample stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/median_feeder.sv
// ============================================================================
// Module      : median_feeder
// Description : Buffers one frame from a valid/ready byte stream, replays it
//               to the median block as a contiguous en burst, returns result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_feeder
  import median_pkg::*;
#(
  parameter int DATA_SAYISI = DATA_SAYISI_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk_i_feeder,
  input  logic              rst_i_feeder,
  input  logic              s_valid_i_feeder,
  input  logic [DATA_W-1:0] s_data_i_feeder,
  output logic              s_ready_o_feeder,
  output logic              en_o_feeder,
  output logic [DATA_W-1:0] data_o_feeder,
  input  logic [DATA_W-1:0] data_i_feeder,
  input  logic              done_i_feeder,
  output logic              m_valid_o_feeder,
  output logic [DATA_W-1:0] m_data_o_feeder,
  input  logic              m_ready_i_feeder,
  output logic              busy_o_feeder,
  output logic              err_o_feeder
);

  localparam int CNT_W = cnt_w(DATA_SAYISI);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(DATA_SAYISI - 1);
  localparam logic [TO_W-1:0]  c_TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  c_TO_END   = TO_W'(TIMEOUT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_s_ready;
  logic               r_en;
  logic               r_m_valid;
  logic               r_busy;
  logic               r_err;
  logic [DATA_W-1:0]  r_m_data;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_accept;
  logic               w_last_in;
  logic               w_last_rd;
  logic               w_done_ok;
  logic               w_to_hit;
  logic               w_xfer;

  assign w_accept  = (r_state == S_FILL) && r_s_ready && s_valid_i_feeder;
  assign w_last_in = w_accept && (r_wr_cnt == c_LAST);
  assign w_last_rd = (r_state == S_SEND) && (r_rd_cnt == c_LAST);
  // err fires one cycle before the return to FILL; a done in that final cycle is too late.
  assign w_done_ok = (r_state == S_WAIT) && done_i_feeder && (r_to_cnt != c_TO_END);
  assign w_to_hit  = (r_state == S_WAIT) && !done_i_feeder && (r_to_cnt == c_TO_LAST);
  assign w_xfer    = r_m_valid && m_ready_i_feeder;

  always_ff @(posedge clk_i_feeder) begin
    if (rst_i_feeder) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: if (w_last_in) w_state_nxt = S_SEND;
      S_SEND: if (w_last_rd) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_ok) begin
          w_state_nxt = S_OUT;
        end else if (r_to_cnt == c_TO_END) begin
          w_state_nxt = S_FILL;
        end
      end
      S_OUT:   if (w_xfer) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk_i_feeder) begin
    if (rst_i_feeder) begin
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_to_cnt  <= '0;
      r_s_ready <= 1'b0;
      r_en      <= 1'b0;
      r_m_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_m_data  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_cnt <= w_last_in ? '0 : r_wr_cnt + CNT_W'(1);
      end
      if (r_state == S_SEND) begin
        r_rd_cnt <= w_last_rd ? '0 : r_rd_cnt + CNT_W'(1);
      end
      if (r_state == S_SEND) begin
        r_to_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_done_ok) begin
        r_m_data <= data_i_feeder;
      end
      // en trails the RAM read by one cycle so it lines up with the read data.
      r_en      <= (r_state == S_SEND);
      r_s_ready <= (w_state_nxt == S_FILL);
      r_busy    <= (w_state_nxt != S_FILL);
      r_m_valid <= (w_state_nxt == S_OUT);
      r_err     <= w_to_hit;
    end
  end

  feeder_frame_buf #(
    .DEPTH  (DATA_SAYISI),
    .DATA_W (DATA_W),
    .ADDR_W (CNT_W)
  ) u_frame_buf (
    .clk     (clk_i_feeder),
    .rst     (rst_i_feeder),
    .i_we    (w_accept),
    .i_waddr (r_wr_cnt),
    .i_wdata (s_data_i_feeder),
    .i_re    (r_state == S_SEND),
    .i_raddr (r_rd_cnt),
    .o_rdata (w_rdata)
  );

  assign s_ready_o_feeder = r_s_ready;
  assign en_o_feeder      = r_en;
  assign data_o_feeder    = w_rdata;
  assign m_valid_o_feeder = r_m_valid;
  assign m_data_o_feeder  = r_m_data;
  assign busy_o_feeder    = r_busy;
  assign err_o_feeder     = r_err;

endmodule

`default_nettype wire
